// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing constants, transmitter FSM encoding and clog2 helper
package uart_pkg;
  localparam int CPB_DEFAULT = 20;
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS = 8;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
  function automatic int clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_shift.sv
// uart_tx_shift: 8N1 serializer; load/din start a frame in IDLE, tx idle high, busy over START..STOP, done on last STOP cycle
module uart_tx_shift
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = CPB_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int CW = clog2(CYCLES_PER_BIT);
  tx_state_t r_state, w_next;
  logic [CW-1:0] r_cyc;
  logic [2:0] r_bit;
  logic [7:0] r_sh;
  logic w_bit_end;
  assign w_bit_end = r_cyc == CW'(CYCLES_PER_BIT - 1);
  always_comb begin
    w_next = r_state;
    tx = 1'b1;
    busy = 1'b1;
    done = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        w_next = load ? S_START : S_IDLE;
      end
      S_START: begin
        tx = 1'b0;
        w_next = w_bit_end ? S_DATA : S_START;
      end
      S_DATA: begin
        tx = r_sh[0];
        w_next = (w_bit_end && r_bit == 3'(DATA_BITS - 1)) ? S_STOP : S_DATA;
      end
      S_STOP: begin
        done = w_bit_end;
        w_next = w_bit_end ? S_IDLE : S_STOP;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cyc <= '0;
      r_bit <= '0;
      r_sh <= '0;
    end else begin
      r_state <= w_next;
      r_cyc <= (r_state == S_IDLE || w_bit_end) ? '0 : r_cyc + 1'b1;
      if (r_state == S_IDLE && load) r_sh <= din;
      else if (r_state == S_DATA && w_bit_end) r_sh <= r_sh >> 1;
      if (r_state == S_DATA && w_bit_end) r_bit <= r_bit + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one 8N1 UART tx line among NUM_REQ valid/ready byte producers
// Ports: clk, rst (sync, active high); req_valid/req_data/req_last in, req_ready one-hot out;
//   tx serial line, busy frame in progress, grant_id last accepted requester.
// Option: UART_ARB_LOCK_EN holds the grant on one requester until it presents req_last.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CYCLES_PER_BIT = CPB_DEFAULT,
  localparam int ID_W = clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);
  logic [ID_W-1:0] r_ptr, r_grant, w_win, w_idx, w_next_ptr;
  logic [NUM_REQ-1:0] w_elig;
  logic [7:0] w_byte;
  logic w_found, w_accept, w_done, w_unused;
`ifdef UART_ARB_LOCK_EN
  logic r_lock, w_last;
  assign w_elig = r_lock ? (req_valid & (NUM_REQ'(1) << r_grant)) : req_valid;
  assign w_unused = w_done;
`else
  assign w_elig = req_valid;
  assign w_unused = w_done ^ (^req_last);
`endif
  assign w_accept = w_found && !busy && !rst;
  assign w_next_ptr = ID_W'((int'(w_win) + 1) % NUM_REQ);
  assign grant_id = r_grant;
  // Scan from the far end toward the pointer so the closest eligible index wins.
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win = w_idx;
      end
    end
  end
  always_comb begin
    w_byte = '0;
    req_ready = '0;
`ifdef UART_ARB_LOCK_EN
    w_last = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_accept && w_win == ID_W'(i);
      w_byte = w_win == ID_W'(i) ? req_data[8*i +: 8] : w_byte;
`ifdef UART_ARB_LOCK_EN
      w_last = w_win == ID_W'(i) ? req_last[i] : w_last;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_grant <= '0;
`ifdef UART_ARB_LOCK_EN
      r_lock <= 1'b0;
`endif
    end else if (w_accept) begin
      r_grant <= w_win;
`ifdef UART_ARB_LOCK_EN
      r_lock <= !w_last;
      if (w_last) r_ptr <= w_next_ptr;
`else
      r_ptr <= w_next_ptr;
`endif
    end
  end
  uart_tx_shift #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_shift (
    .clk  (clk),
    .rst  (rst),
    .load (w_accept),
    .din  (w_byte),
    .tx   (tx),
    .busy (busy),
    .done (w_done)
  );
endmodule
